// File: rtl/i2c_slave_if.sv
// User-side bundle of the I2C target: received bytes out, read bytes in.
// The slave modport belongs to the target, master to the consuming logic.
interface i2c_slave_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;

  modport slave (
    output rx_data,
    output rx_valid,
    output tx_req,
    output busy,
    input  tx_data
  );

  modport master (
    input  rx_data,
    input  rx_valid,
    input  tx_req,
    input  busy,
    output tx_data
  );
endinterface

// File: rtl/i2c_slave.sv
// I2C target with a fixed 7-bit address, oversampled on the system clock.
// Written bytes leave on rx_*, read bytes are requested through tx_req.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h34,
  parameter bit         MSB_FIRST  = 1'b1
) (
  input  logic       clk,
  input  logic       arstn,
  input  logic       scl,
  inout  wire        sda,
  i2c_slave_if.slave usr
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_e;

  state_e     state_q;
  logic [2:0] scl_q;
  logic [2:0] sda_q;
  logic [2:0] cnt_q;
  logic [7:0] sh_q;
  logic       oe_q;
  logic       rw_q;
  logic       ack_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       tx_req_q;
  logic       busy_q;

  logic       scl_s;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start;
  logic       stop;
  logic [7:0] byte_in;
  logic [7:0] tx_ord;
  logic [7:0] rx_ord;

  function automatic logic [7:0] rev8(
    input logic [7:0] v
  );
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r;
  endfunction

  assign scl_s    = scl_q[1];
  assign sda_s    = sda_q[1];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = scl_s & sda_q[2] & ~sda_s;
  assign stop     = scl_s & ~sda_q[2] & sda_s;
  assign byte_in  = {sh_q[6:0], sda_s};

  // Shift register always holds wire order; reorder at the user boundary.
  assign tx_ord = MSB_FIRST ? usr.tx_data : rev8(usr.tx_data);
  assign rx_ord = MSB_FIRST ? byte_in : rev8(byte_in);

  assign sda          = oe_q ? 1'b0 : 1'bz;
  assign usr.rx_data  = rx_data_q;
  assign usr.rx_valid = rx_valid_q;
  assign usr.tx_req   = tx_req_q;
  assign usr.busy     = busy_q;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= IDLE;
      scl_q      <= 3'b111;
      sda_q      <= 3'b111;
      cnt_q      <= 3'd0;
      sh_q       <= 8'h00;
      oe_q       <= 1'b0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      scl_q      <= {scl_q[1:0], scl};
      sda_q      <= {sda_q[1:0], sda};
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      if (stop) begin
        state_q <= IDLE;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else if (start) begin
        state_q <= ADDR;
        cnt_q   <= 3'd0;
        oe_q    <= 1'b0;
        ack_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE, WAIT_STOP: begin
          end
          ADDR: begin
            if (scl_rise) begin
              sh_q  <= byte_in;
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                if (byte_in[7:1] == SLAVE_ADDR) begin
                  busy_q   <= 1'b1;
                  rw_q     <= byte_in[0];
                  tx_req_q <= byte_in[0];
                  state_q  <= ADDR_ACK;
                end else begin
                  state_q <= WAIT_STOP;
                end
              end
            end
          end
          // oe_q doubles as the phase flag: first fall drives the ACK,
          // second fall ends it.
          ADDR_ACK: begin
            if (scl_fall) begin
              cnt_q <= 3'd0;
              if (!oe_q) begin
                oe_q <= 1'b1;
              end else if (rw_q) begin
                sh_q    <= tx_ord;
                oe_q    <= ~tx_ord[7];
                state_q <= RD_DATA;
              end else begin
                oe_q    <= 1'b0;
                state_q <= WR_DATA;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              sh_q  <= byte_in;
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                rx_data_q  <= rx_ord;
                rx_valid_q <= 1'b1;
                state_q    <= WR_ACK;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              if (!oe_q) begin
                oe_q <= 1'b1;
              end else begin
                oe_q    <= 1'b0;
                state_q <= WR_DATA;
              end
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                oe_q    <= 1'b0;
                ack_q   <= 1'b0;
                state_q <= RD_ACK;
              end else begin
                sh_q <= {sh_q[6:0], 1'b0};
                oe_q <= ~sh_q[6];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                ack_q    <= 1'b1;
                tx_req_q <= 1'b1;
              end else begin
                busy_q  <= 1'b0;
                state_q <= WAIT_STOP;
              end
            end else if (scl_fall && ack_q) begin
              sh_q    <= tx_ord;
              oe_q    <= ~tx_ord[7];
              cnt_q   <= 3'd0;
              ack_q   <= 1'b0;
              state_q <= RD_DATA;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench: a bit-banged I2C master drives two targets on one bus,
// one MSB-first at 0x34 and one LSB-first at 0x22.
module tb_i2c_slave;
  localparam int H = 20;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  logic scl = 1'b1;
  logic m_low = 1'b0;
  wire  sda;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave_if if1 ();
  i2c_slave_if if2 ();

  i2c_slave #(.SLAVE_ADDR(7'h34), .MSB_FIRST(1'b1)) u1 (
    .clk  (clk),
    .arstn(arstn),
    .scl  (scl),
    .sda  (sda),
    .usr  (if1)
  );

  i2c_slave #(.SLAVE_ADDR(7'h22), .MSB_FIRST(1'b0)) u2 (
    .clk  (clk),
    .arstn(arstn),
    .scl  (scl),
    .sda  (sda),
    .usr  (if2)
  );

  assign if2.tx_data = 8'h00;

  int total = 0;
  int bad = 0;

  int rx1_cnt = 0;
  int rx2_cnt = 0;
  int tx_cnt = 0;
  int busy1_cyc = 0;
  int busy2_cyc = 0;
  logic [7:0] rx1_log [256];
  logic [7:0] rx2_log [256];
  logic [7:0] txq [8];

  initial begin
    txq[0] = 8'h10; txq[1] = 8'h11; txq[2] = 8'h12; txq[3] = 8'h13;
    txq[4] = 8'hC3; txq[5] = 8'h00; txq[6] = 8'h00; txq[7] = 8'h00;
  end

  always @(posedge clk) begin
    if (if1.rx_valid) begin
      rx1_log[rx1_cnt[7:0]] <= if1.rx_data;
      rx1_cnt <= rx1_cnt + 1;
    end
    if (if2.rx_valid) begin
      rx2_log[rx2_cnt[7:0]] <= if2.rx_data;
      rx2_cnt <= rx2_cnt + 1;
    end
    if (if1.tx_req) begin
      if1.tx_data <= txq[tx_cnt[2:0]];
      tx_cnt <= tx_cnt + 1;
    end
    if (if1.busy) busy1_cyc <= busy1_cyc + 1;
    if (if2.busy) busy2_cyc <= busy2_cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic hw(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start();
    m_low = 1'b0; hw(H);
    scl = 1'b1;   hw(H);
    m_low = 1'b1; hw(H);
    scl = 1'b0;   hw(H);
  endtask

  task automatic m_stop();
    m_low = 1'b1; hw(H);
    scl = 1'b1;   hw(H);
    m_low = 1'b0; hw(H);
  endtask

  task automatic m_bit(input logic b, output logic r);
    m_low = ~b; hw(H);
    scl = 1'b1; hw(H/2);
    r = (sda !== 1'b0);
    hw(H/2);
    scl = 1'b0;
  endtask

  task automatic m_wr(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(b[i], r);
    m_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic m_rd(input logic ack, output logic [7:0] b);
    logic r;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m_bit(1'b1, r);
      b = {b[6:0], r};
    end
    m_bit(~ack, r);
  endtask

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
    logic       aack;
    int         n1;
    logic [7:0] rx1;
    int         n2;
    logic [7:0] rx2;
  } vec_t;

  vec_t v [6];

  initial begin
    logic       a;
    logic [7:0] d;
    int r1, r2, t0, b1, b2;

    v[0] = '{7'h34, 8'h5A, 1'b1, 1, 8'h5A, 0, 8'h00};
    v[1] = '{7'h34, 8'h81, 1'b1, 1, 8'h81, 0, 8'h00};
    v[2] = '{7'h35, 8'h5A, 1'b0, 0, 8'h00, 0, 8'h00};
    v[3] = '{7'h22, 8'h12, 1'b1, 0, 8'h00, 1, 8'h48};
    v[4] = '{7'h22, 8'h01, 1'b1, 0, 8'h00, 1, 8'h80};
    v[5] = '{7'h22, 8'hA5, 1'b1, 0, 8'h00, 1, 8'hA5};

    hw(5);
    chk("rst_rx_data", if1.rx_data, 8'h00);
    chk("rst_rx_valid", if1.rx_valid, 1'b0);
    chk("rst_tx_req", if1.tx_req, 1'b0);
    chk("rst_busy", if1.busy, 1'b0);
    chk("rst_sda", sda !== 1'b0, 1'b1);
    arstn = 1'b1;
    hw(5);

    for (int i = 0; i < 6; i++) begin
      r1 = rx1_cnt; r2 = rx2_cnt; b1 = busy1_cyc; b2 = busy2_cyc;
      m_start();
      m_wr({v[i].addr, 1'b0}, a);
      chk($sformatf("v%0d_addr_ack", i), a, v[i].aack);
      m_wr(v[i].data, a);
      chk($sformatf("v%0d_data_ack", i), a, v[i].aack);
      m_stop();
      hw(4);
      chk($sformatf("v%0d_rx1_n", i), rx1_cnt - r1, v[i].n1);
      chk($sformatf("v%0d_rx2_n", i), rx2_cnt - r2, v[i].n2);
      if (v[i].n1 > 0) chk($sformatf("v%0d_rx1", i), rx1_log[r1[7:0]], v[i].rx1);
      if (v[i].n2 > 0) chk($sformatf("v%0d_rx2", i), rx2_log[r2[7:0]], v[i].rx2);
      chk($sformatf("v%0d_busy_seen", i),
          {busy1_cyc != b1, busy2_cyc != b2}, {v[i].n1 > 0, v[i].n2 > 0});
      chk($sformatf("v%0d_busy_end", i), {if1.busy, if2.busy}, 2'b00);
    end

    // three-byte write in one transaction
    r1 = rx1_cnt;
    m_start();
    m_wr(8'h68, a); chk("mw_addr_ack", a, 1'b1);
    m_wr(8'hA5, a); chk("mw_ack0", a, 1'b1);
    m_wr(8'h3C, a); chk("mw_ack1", a, 1'b1);
    m_wr(8'hFF, a); chk("mw_ack2", a, 1'b1);
    m_stop(); hw(4);
    chk("mw_n", rx1_cnt - r1, 3);
    chk("mw_b0", rx1_log[r1[7:0]], 8'hA5);
    chk("mw_b1", rx1_log[8'(r1 + 1)], 8'h3C);
    chk("mw_b2", rx1_log[8'(r1 + 2)], 8'hFF);

    // four-byte read, NACK on the last
    t0 = tx_cnt;
    m_start();
    m_wr(8'h69, a); chk("rd_addr_ack", a, 1'b1);
    m_rd(1'b1, d); chk("rd_b0", d, 8'h10);
    m_rd(1'b1, d); chk("rd_b1", d, 8'h11);
    m_rd(1'b1, d); chk("rd_b2", d, 8'h12);
    m_rd(1'b0, d); chk("rd_b3", d, 8'h13);
    hw(4);
    chk("rd_tx_req_n", tx_cnt - t0, 4);
    chk("rd_busy_after_nack", if1.busy, 1'b0);
    chk("rd_sda_released", sda !== 1'b0, 1'b1);
    m_stop(); hw(4);

    // write then repeated START into a read
    r1 = rx1_cnt;
    m_start();
    m_wr(8'h68, a); chk("rs_waddr_ack", a, 1'b1);
    m_wr(8'h55, a); chk("rs_data_ack", a, 1'b1);
    m_start();
    chk("rs_busy_cleared", if1.busy, 1'b0);
    m_wr(8'h69, a); chk("rs_raddr_ack", a, 1'b1);
    m_rd(1'b0, d); chk("rs_read", d, 8'hC3);
    m_stop(); hw(4);
    chk("rs_rx_n", rx1_cnt - r1, 1);
    chk("rs_rx", rx1_log[r1[7:0]], 8'h55);

    // STOP after four data bits discards the partial byte
    r1 = rx1_cnt;
    m_start();
    m_wr(8'h68, a); chk("ps_addr_ack", a, 1'b1);
    m_bit(1'b1, a); m_bit(1'b0, a); m_bit(1'b1, a); m_bit(1'b0, a);
    m_stop(); hw(4);
    chk("ps_rx_n", rx1_cnt - r1, 0);
    chk("ps_busy", if1.busy, 1'b0);
    m_start();
    m_wr(8'h68, a); chk("ps2_addr_ack", a, 1'b1);
    m_wr(8'h7E, a); chk("ps2_data_ack", a, 1'b1);
    m_stop(); hw(4);
    chk("ps2_rx_n", rx1_cnt - r1, 1);
    chk("ps2_rx", rx1_log[r1[7:0]], 8'h7E);

    // reset while the target drives a 0 data bit
    m_start();
    m_wr(8'h69, a); chk("ar_addr_ack", a, 1'b1);
    hw(8);
    chk("ar_sda_driven", sda === 1'b0, 1'b1);
    arstn = 1'b0;
    #1;
    chk("ar_sda", sda !== 1'b0, 1'b1);
    chk("ar_rx_data", if1.rx_data, 8'h00);
    chk("ar_rx_valid", if1.rx_valid, 1'b0);
    chk("ar_tx_req", if1.tx_req, 1'b0);
    chk("ar_busy", if1.busy, 1'b0);
    hw(4);
    arstn = 1'b1;
    hw(4);
    m_stop(); hw(4);
    r1 = rx1_cnt;
    m_start();
    m_wr(8'h68, a); chk("ar2_addr_ack", a, 1'b1);
    m_wr(8'h99, a); chk("ar2_data_ack", a, 1'b1);
    m_stop(); hw(4);
    chk("ar2_rx_n", rx1_cnt - r1, 1);
    chk("ar2_rx", rx1_log[r1[7:0]], 8'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- Synthesizable I2C target (slave) that answers the existing i2c master on the same two-wire bus.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a fixed 7-bit address and ACKs it.
- Delivers written bytes to user logic and requests bytes from user logic for master reads.
- Replaces the behavioural slave agent in system-level benches; also usable as an on-chip register-bank front end.

Parameters:
- SLAVE_ADDR, 7'h34, 7-bit address this target responds to.
- MSB_FIRST, 1, bit order of data bytes (1 = MSB first). The address byte is always MSB first.

Ports:
- clk  in  1  system clock (100 MHz nominal).
- arstn  in  1  asynchronous active-low reset.
- scl  in  1  I2C clock from master. Asynchronous; no clock stretching is performed.
- sda  inout  1  I2C data, open drain: driven 1'b0 or 1'bz only.
- rx_data  out  8  last byte written by the master.
- rx_valid  out  1  one-cycle pulse; rx_data is valid in that cycle.
- tx_data  in  8  byte to return on a master read; sampled as defined below.
- tx_req  out  1  one-cycle pulse requesting the next tx_data.
- busy  out  1  high from address match until STOP, repeated START, or NACK termination.

Behaviour:
- Reset (arstn=0, asynchronous):
  - sda released (z); rx_data=0; rx_valid=0; tx_req=0; busy=0.
  - State=IDLE; synchronizers preset to 1.
- Input conditioning:
  - scl and sda pass through 2-flop synchronizers, plus one delayed copy for edge detection (3-cycle latency).
  - scl_rise / scl_fall are single-cycle strobes.
- START: synced sda falls while synced scl=1.
  - Accepted from any state, including mid-byte, as a repeated START.
  - Clears the bit counter; goes to ADDR; busy=0.
- STOP: synced sda rises while synced scl=1.
  - From any state: go to IDLE, release sda, busy=0.
  - A partial byte is discarded; no rx_valid.
- Bit timing:
  - Sample sda on scl_rise.
  - Update the driven sda on scl_fall, so output hold after SCL falls is 3-4 clk.
  - 3-bit counter, 8 data bits then 1 ACK bit.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- IDLE: sda=z; waits for START.
- ADDR: shift 8 bits. On the 8th scl_rise:
  - addr==SLAVE_ADDR: busy=1 and go to ADDR_ACK. If R/W=1, pulse tx_req in the same cycle.
  - Mismatch: go to WAIT_STOP; sda untouched (master sees NACK).
- ADDR_ACK:
  - Drive sda=0 from the scl_fall after bit 8 until the next scl_fall.
  - At that fall: latch tx_data (read) and go to RD_DATA, or go to WR_DATA (write).
- WR_DATA: shift 8 bits. On the 8th scl_rise:
  - rx_data <= assembled byte (bit-reversed if MSB_FIRST=0).
  - rx_valid pulses for 1 clk.
  - Go to WR_ACK.
- WR_ACK: always ACK (sda=0 for one SCL period); then back to WR_DATA.
- RD_DATA: drive each shift-register bit on scl_fall. Bit 7 (or bit 0 when MSB_FIRST=0) is already driven at the ADDR_ACK/RD_ACK exit fall. After the 8th bit's scl_fall, release sda and go to RD_ACK.
- RD_ACK: sample the master's ACK on scl_rise.
  - sda=0 (ACK): pulse tx_req; at the next scl_fall latch tx_data and go to RD_DATA.
  - sda=1 (NACK): busy=0, sda=z, go to WAIT_STOP.
- WAIT_STOP: ignore everything except START and STOP.
- tx_data contract:
  - User logic must present the byte within 1 SCL half-period of tx_req (≥400 clk at 100 kHz / 100 MHz).
  - A 1-cycle combinational response is also acceptable.
- Simultaneous events: START/STOP detection has priority over scl edges in the same cycle.
- sda is never driven while synced scl=1, except when holding a bit already set on the previous fall.

Test Plan:
- Write 3 bytes A5,3C,FF to address 0x34 → rx_valid pulses 3 times with rx_data A5,3C,FF. Slave ACKs address and all data (sda=0 at 9th SCL each byte).
- Read 4 bytes from 0x34, tx_data returning 10,11,12,13 on successive tx_req; master NACKs the last byte → master receives 10..13. Exactly 4 tx_req pulses; busy drops after the NACK; sda=z.
- Address 0x35 write → no ACK (sda stays 1 at 9th clock), no rx_valid, busy=0 throughout.
- Write 0x55, then repeated START with read, tx_data=0xC3 → rx_data=55 once; master reads C3; FSM goes through ADDR without passing IDLE.
- STOP injected after 4 bits of a write byte → no rx_valid, busy=0, next transaction to 0x34 with 0x7E is received correctly.
- arstn asserted mid-read while driving 0 → sda=z within the same cycle, all outputs at reset values, next write 0x99 is received correctly.
- Repeat the write scenario with MSB_FIRST=0 → rx_data bit-reversed relative to the wire order.
